// File: rtl/mem_write_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mem_write_sequencer_pkg
// Shared definitions for the memory write sequencer:
//   - default address / data widths and the largest CPU store size
//   - FSM state encoding (IDLE / CPU_WR / DMA_WR)
//   - last-grant encoding used by the round-robin arbiter
//   - requester bit positions inside the two-bit req/gnt vectors
//   - helper deciding whether the pipeline must stay frozen
// ----------------------------------------------------------------------------
package mem_write_sequencer_pkg;

  localparam int ADR_W = 16;  // default address width
  localparam int DAT_W = 8;   // default byte width
  localparam int MAX_B = 3;   // largest CPU store in bytes
  localparam int CNT_W = 2;   // width of the CPU byte-count field

  // Requester positions inside the req/gnt vectors of the arbiter.
  localparam int IDX_CPU = 0;
  localparam int IDX_DMA = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_WR = 2'd1,
    DMA_WR = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_e;

  // The pipeline stays frozen while more than one byte (the one on the
  // bus in that cycle included) is still left to write.
  function automatic logic stall_for(input logic [CNT_W-1:0] bytes_left);
    return (bytes_left > CNT_W'(1));
  endfunction

endpackage

// File: rtl/mem_write_sequencer_rr_arb2.sv
// ----------------------------------------------------------------------------
// mem_write_sequencer_rr_arb2
// Two-requester round-robin arbiter with a last-grant register.
// A grant is only possible while slot_en is high; on a tie the requester
// that was not granted last wins. last_gnt resets to DMA, so the CPU wins
// the first tie after reset.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   slot_en  in   accept slot; no grant outside it
//   req      in   [IDX_CPU]=CPU request, [IDX_DMA]=DMA request
//   gnt      out  one-hot combinational grant, same bit order as req
// ----------------------------------------------------------------------------
module mem_write_sequencer_rr_arb2
  import mem_write_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       slot_en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  gnt_e last_gnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic last_was_me;
      assign last_was_me = (last_gnt_reg == ((gi == IDX_CPU) ? GNT_CPU : GNT_DMA));
      // Win when the other side is quiet, or on a tie when the previous
      // grant went to the other side.
      assign gnt[gi] = slot_en & req[gi] & (~req[1-gi] | ~last_was_me);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_gnt_reg <= GNT_DMA;
    end else if (|gnt) begin
      last_gnt_reg <= gnt[IDX_DMA] ? GNT_DMA : GNT_CPU;
    end
  end

endmodule

// File: rtl/mem_write_sequencer.sv
// ----------------------------------------------------------------------------
// mem_write_sequencer
// Write-port controller in front of a single-byte-write memory. Arbitrates
// between the pipeline store stage (1..3 byte little-endian stores) and a
// DMA/loader port (single byte), then serialises the granted request into
// one byte write per clock. Stalls the pipeline while a multi-byte store
// drains.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_n_i    in   asynchronous active-low reset
//   cpu_req_i  in   CPU write request, held until granted
//   cpu_cnt_i  in   CPU byte count 0..3 (0 = accepted, nothing written)
//   cpu_adr_i  in   address of CPU byte 0
//   cpu_dat_i  in   CPU bytes, lowest byte = byte 0
//   cpu_gnt_o  out  combinational CPU accept strobe
//   cpu_stl_o  out  registered pipeline stall
//   dma_req_i  in   DMA single-byte write request, held until granted
//   dma_adr_i  in   DMA address
//   dma_dat_i  in   DMA byte
//   dma_gnt_o  out  combinational DMA accept strobe
//   mem_we_o   out  registered byte write enable
//   mem_adr_o  out  registered write address
//   mem_dat_o  out  registered write byte
//   busy_o     out  registered, high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mem_write_sequencer
  import mem_write_sequencer_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_W,
  parameter int DAT_WIDTH = DAT_W,
  parameter int MAX_BYTES = MAX_B
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           cpu_req_i,
  input  logic [CNT_W-1:0]               cpu_cnt_i,
  input  logic [ADR_WIDTH-1:0]           cpu_adr_i,
  input  logic [MAX_BYTES*DAT_WIDTH-1:0] cpu_dat_i,
  output logic                           cpu_gnt_o,
  output logic                           cpu_stl_o,
  input  logic                           dma_req_i,
  input  logic [ADR_WIDTH-1:0]           dma_adr_i,
  input  logic [DAT_WIDTH-1:0]           dma_dat_i,
  output logic                           dma_gnt_o,
  output logic                           mem_we_o,
  output logic [ADR_WIDTH-1:0]           mem_adr_o,
  output logic [DAT_WIDTH-1:0]           mem_dat_o,
  output logic                           busy_o
);

  localparam int SHW = MAX_BYTES * DAT_WIDTH;

  state_e                 state_reg;
  logic [CNT_W-1:0]       rem_reg;     // bytes left, counting the one on mem_* now
  logic [SHW-1:0]         shift_reg;   // bytes still to emit, next one in the low lane
  logic                   mem_we_reg;
  logic [ADR_WIDTH-1:0]   mem_adr_reg;
  logic [DAT_WIDTH-1:0]   mem_dat_reg;
  logic                   cpu_stl_reg;
  logic                   busy_reg;

  logic [SHW-1:0]         shift_down;  // shift_reg moved down one lane
  logic [SHW-1:0]         cpu_down;    // cpu_dat_i without byte 0
  logic                   final_cycle;
  logic                   slot_en;
  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   cpu_load;

  // Lane-wise right shift by one byte; the top lane fills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
      if (gi < MAX_BYTES - 1) begin : g_mid
        assign shift_down[gi*DAT_WIDTH +: DAT_WIDTH] = shift_reg[(gi+1)*DAT_WIDTH +: DAT_WIDTH];
        assign cpu_down[gi*DAT_WIDTH +: DAT_WIDTH]   = cpu_dat_i[(gi+1)*DAT_WIDTH +: DAT_WIDTH];
      end else begin : g_top
        assign shift_down[gi*DAT_WIDTH +: DAT_WIDTH] = '0;
        assign cpu_down[gi*DAT_WIDTH +: DAT_WIDTH]   = '0;
      end
    end
  endgenerate

  // A DMA write is always a single (hence final) byte; a CPU burst is in
  // its final byte when exactly one byte is left.
  assign final_cycle = (state_reg == DMA_WR) ||
                       ((state_reg == CPU_WR) && (rem_reg == CNT_W'(1)));

  // Gating with rst_n_i keeps both grants low throughout reset.
  assign slot_en = rst_n_i && ((state_reg == IDLE) || final_cycle);

  assign req[IDX_CPU] = cpu_req_i;
  assign req[IDX_DMA] = dma_req_i;

  mem_write_sequencer_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .slot_en (slot_en),
    .req     (req),
    .gnt     (gnt)
  );

  assign cpu_gnt_o = gnt[IDX_CPU];
  assign dma_gnt_o = gnt[IDX_DMA];

  // A zero-byte CPU grant is only an acknowledge; it never starts a burst.
  assign cpu_load = gnt[IDX_CPU] && (cpu_cnt_i != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      shift_reg   <= '0;
      mem_we_reg  <= 1'b0;
      mem_adr_reg <= '0;
      mem_dat_reg <= '0;
      cpu_stl_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (cpu_load) begin
      // Byte 0 goes straight to the bus; the rest wait in the shifter.
      state_reg   <= CPU_WR;
      rem_reg     <= cpu_cnt_i;
      shift_reg   <= cpu_down;
      mem_we_reg  <= 1'b1;
      mem_adr_reg <= cpu_adr_i;
      mem_dat_reg <= cpu_dat_i[DAT_WIDTH-1:0];
      cpu_stl_reg <= stall_for(cpu_cnt_i);
      busy_reg    <= 1'b1;
    end else if (gnt[IDX_DMA]) begin
      state_reg   <= DMA_WR;
      rem_reg     <= CNT_W'(1);
      shift_reg   <= '0;
      mem_we_reg  <= 1'b1;
      mem_adr_reg <= dma_adr_i;
      mem_dat_reg <= dma_dat_i;
      cpu_stl_reg <= 1'b0;
      busy_reg    <= 1'b1;
    end else if ((state_reg == CPU_WR) && !final_cycle) begin
      // Next byte of the burst; the address wraps naturally at 2^ADR_WIDTH.
      rem_reg     <= rem_reg - CNT_W'(1);
      shift_reg   <= shift_down;
      mem_we_reg  <= 1'b1;
      mem_adr_reg <= mem_adr_reg + ADR_WIDTH'(1);
      mem_dat_reg <= shift_reg[DAT_WIDTH-1:0];
      cpu_stl_reg <= stall_for(rem_reg - CNT_W'(1));
      busy_reg    <= 1'b1;
    end else begin
      // Idle, or the last byte went out with no follow-on grant. The
      // address and data hold their last values; only the strobe drops.
      state_reg   <= IDLE;
      rem_reg     <= '0;
      mem_we_reg  <= 1'b0;
      cpu_stl_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end
  end

  assign mem_we_o  = mem_we_reg;
  assign mem_adr_o = mem_adr_reg;
  assign mem_dat_o = mem_dat_reg;
  assign cpu_stl_o = cpu_stl_reg;
  assign busy_o    = busy_reg;

endmodule
